// File: rtl/flash_reader_pkg.sv
// Shared definitions for the flash_reader block.
// Holds the FSM state enum, the SPI read opcode and the word/address/count
// widths used by the top level, the SPI shifter and the testbench.
package flash_reader_pkg;

  localparam int WORD_W  = 32;
  localparam int ADDR_W  = 24;
  localparam int COUNT_W = 20;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    POWER_WAIT = 3'd0,
    IDLE       = 3'd1,
    SEND       = 3'd2,
    READ       = 3'd3,
    STALL      = 3'd4,
    FINISH     = 3'd5
  } state_t;

endpackage

// File: rtl/flash_reader_spi_shifter.sv
// spi_shifter: SPI mode-0 bit engine for flash_reader.
// Generates the serial clock from clk (HALF_PERIOD clk cycles per level),
// shifts a 32-bit command out MSB first (changing on falling edges) and
// samples miso on rising edges into an 8-bit receive register.
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   load          - load load_data into the transmit register, restart counters
//   run           - clock generation enabled; low forces sclk low
//   pause         - blocks the next low->high transition (clock frozen low)
//   load_data     - 32-bit word to transmit
//   miso          - serial data from the flash
//   sclk          - generated serial clock (registered)
//   mosi          - current transmit bit
//   byte_done     - one-cycle pulse: rx_byte holds a freshly completed byte
//   rx_byte       - last 8 sampled bits, first sampled bit in [7]
module spi_shifter #(
  parameter int HALF_PERIOD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        run,
  input  logic        pause,
  input  logic [31:0] load_data,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        byte_done,
  output logic [7:0]  rx_byte
);

  localparam int DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [31:0]      tx;
  logic [7:0]       rx;
  logic [2:0]       bit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk      <= 1'b0;
      div_cnt   <= '0;
      tx        <= '0;
      rx        <= '0;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (load) begin
        sclk    <= 1'b0;
        div_cnt <= '0;
        tx      <= load_data;
        rx      <= '0;
        bit_cnt <= '0;
      end else if (!run) begin
        sclk    <= 1'b0;
        div_cnt <= '0;
      end else if (pause && !sclk) begin
        // Frozen low: the low phase restarts in full once pause drops.
        div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
        if (!sclk) begin
          // Rising edge: sample miso.
          rx      <= {rx[6:0], miso};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) byte_done <= 1'b1;
        end else begin
          // Falling edge: present the next bit; zeros fill behind the command.
          tx <= {tx[30:0], 1'b0};
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  assign mosi    = tx[31];
  assign rx_byte = rx;

endmodule

// File: rtl/flash_reader.sv
// flash_reader: streams 32-bit words out of an SPI NOR flash (opcode 03h).
// After reset it waits STARTUP_WAIT+1 cycles for flash power-up, then accepts
// start requests. Each transfer sends {03h, start_address} and reads
// word_count little-endian words, presented on a valid/ready output.
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   start           - one-cycle transfer request (only honoured in IDLE)
//   start_address   - 24-bit flash byte address
//   word_count      - number of 32-bit words to read (0 = none)
//   data_out        - assembled word, first byte read in [7:0]
//   data_valid      - data_out holds an unconsumed word
//   data_ready      - consumer accepts data_out
//   busy            - high in every state except IDLE
//   done            - one-cycle pulse at transfer completion
//   flash_clk/mosi/miso/cs - SPI mode 0 flash interface, cs active low
//   state           - current FSM state (debug observation)
// Output handshake: a word transfers in any cycle where data_valid && data_ready;
// data_out and data_valid are stable while data_valid is high and data_ready low.
module flash_reader
  import flash_reader_pkg::*;
#(
  parameter int STARTUP_WAIT = 1_000_000,
  parameter int HALF_PERIOD  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_address,
  input  logic [COUNT_W-1:0] word_count,
  output logic [WORD_W-1:0]  data_out,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               busy,
  output logic               done,
  output logic               flash_clk,
  output logic               flash_mosi,
  input  logic               flash_miso,
  output logic               flash_cs,
  output state_t             state
);

  localparam logic [31:0] WAIT_LAST = 32'(STARTUP_WAIT);

  state_t             state_next;
  logic [31:0]        wait_cnt;
  logic [COUNT_W-1:0] words_left;
  logic [1:0]         byte_idx;
  logic [WORD_W-1:0]  asm_word;

  logic               load;
  logic               push;
  logic               link_active;
  logic               last_word;
  logic               out_free;
  logic [WORD_W-1:0]  new_word;

  logic               sclk;
  logic               mosi;
  logic               byte_done;
  logic [7:0]         rx_byte;

  assign link_active = (state == SEND) || (state == READ) || (state == STALL);
  assign last_word   = (words_left == COUNT_W'(1));
  assign out_free    = !data_valid || data_ready;
  // In STALL the held word already contains its 4th byte.
  assign new_word    = (state == STALL) ? asm_word : {rx_byte, asm_word[23:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= POWER_WAIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    push       = 1'b0;
    case (state)
      POWER_WAIT: if (wait_cnt == WAIT_LAST) state_next = IDLE;
      IDLE: begin
        if (start) begin
          if (word_count == '0) begin
            state_next = FINISH;
          end else begin
            state_next = SEND;
            load       = 1'b1;
          end
        end
      end
      SEND: if (byte_done && byte_idx == 2'd3) state_next = READ;
      READ: begin
        if (byte_done && byte_idx == 2'd3) begin
          if (out_free) begin
            push       = 1'b1;
            state_next = last_word ? FINISH : READ;
          end else begin
            state_next = STALL;
          end
        end
      end
      STALL: begin
        if (data_ready) begin
          push       = 1'b1;
          state_next = last_word ? FINISH : READ;
        end
      end
      FINISH: if (!data_valid) state_next = IDLE;
      default: state_next = POWER_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      asm_word   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      if (state == POWER_WAIT) wait_cnt <= wait_cnt + 32'd1;
      if (state == IDLE && start) begin
        words_left <= word_count;
        byte_idx   <= '0;
      end
      // Bytes are counted in SEND too, so READ begins on a byte boundary.
      if ((state == SEND || state == READ) && byte_done) begin
        byte_idx <= byte_idx + 2'd1;
        if (state == READ) asm_word[{byte_idx, 3'b000} +: 8] <= rx_byte;
      end
      if (push) begin
        data_out   <= new_word;
        data_valid <= 1'b1;
        words_left <= words_left - COUNT_W'(1);
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

  spi_shifter #(.HALF_PERIOD(HALF_PERIOD)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .run       (link_active),
    .pause     (state == STALL),
    .load_data ({FLASH_CMD_READ, start_address}),
    .miso      (flash_miso),
    .sclk      (sclk),
    .mosi      (mosi),
    .byte_done (byte_done),
    .rx_byte   (rx_byte)
  );

  // Gating with link_active drops the clock on the same edge that raises cs.
  assign flash_clk  = sclk & link_active;
  assign flash_mosi = mosi & link_active;
  assign flash_cs   = ~link_active;
  assign busy       = (state != IDLE);
  assign done       = (state == FINISH) && !data_valid;

endmodule

// File: tb/tb_flash_reader.sv
// Testbench for flash_reader: behavioural SPI flash model, scoreboard of
// expected words/commands computed from the start arguments, and directed plus
// randomized transfers.
module tb_flash_reader;
  import flash_reader_pkg::*;

  localparam int STARTUP_WAIT = 10;
  localparam int HALF_PERIOD  = 1;
  localparam int BUDGET       = 5000;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [ADDR_W-1:0]  start_address;
  logic [COUNT_W-1:0] word_count;
  logic [WORD_W-1:0]  data_out;
  logic               data_valid;
  logic               data_ready;
  logic               busy;
  logic               done;
  logic               flash_clk;
  logic               flash_mosi;
  logic               flash_miso = 1'b0;
  logic               flash_cs;
  state_t             state;

  flash_reader #(.STARTUP_WAIT(STARTUP_WAIT), .HALF_PERIOD(HALF_PERIOD)) dut (
    .clk(clk), .rst(rst), .start(start), .start_address(start_address),
    .word_count(word_count), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .busy(busy), .done(done), .flash_clk(flash_clk),
    .flash_mosi(flash_mosi), .flash_miso(flash_miso), .flash_cs(flash_cs),
    .state(state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cmd_q[$];
  int done_cnt = 0;
  int last_done_cycle = 0;
  int words_seen = 0;
  logic [31:0] last_word = '0;
  int cs_falls = 0;
  int clk_rises = 0;
  int hi_len = 0;
  int ready_mode = 0;
  int start_cycle = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mem [1024];

  function automatic logic [7:0] ref_byte(input logic [23:0] a);
    return mem[a[9:0]];
  endfunction

  // Word k of a transfer: bytes at a+4k .. a+4k+3 (24-bit wrap), first byte low.
  function automatic logic [31:0] ref_word(input logic [23:0] a, input int k);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = ref_byte(a + 24'(4*k + j));
    return w;
  endfunction

  // ---------------- SPI flash model ----------------
  int f_bits = 0;
  logic [31:0] f_cmd = '0;

  always @(negedge flash_cs) begin
    f_bits = 0;
    f_cmd  = '0;
    cs_falls++;
  end

  always @(posedge flash_clk) begin
    clk_rises++;
    if (!flash_cs) begin
      if (f_bits < 32) f_cmd = {f_cmd[30:0], flash_mosi};
      else check("mosi_zero_in_read", flash_mosi, 0);
      f_bits++;
      if (f_bits == 32) begin
        if (cmd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_command actual=%h required=none", f_cmd);
        end else begin
          check("command", f_cmd, cmd_q.pop_front());
        end
      end
    end
  end

  always @(negedge flash_clk) begin
    if (!flash_cs && f_bits >= 32) begin
      int n;
      logic [7:0] b;
      n = f_bits - 32;
      b = ref_byte(f_cmd[23:0] + 24'(n / 8));
      flash_miso = b[7 - (n % 8)];
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (data_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_word actual=%h required=none", data_out);
      end else begin
        check("word", data_out, exp_q.pop_front());
      end
      last_word = data_out;
      words_seen++;
    end
    if (done) begin
      done_cnt++;
      last_done_cycle = cyc;
    end
    if (flash_cs) check("clk_low_when_deselected", flash_clk, 0);
    if (flash_clk) begin
      hi_len++;
    end else begin
      if (hi_len > 0 && !flash_cs) check("clk_high_len", hi_len, HALF_PERIOD);
      hi_len = 0;
    end
  end

  // ---------------- ready driver ----------------
  initial begin
    data_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       data_ready = 1'b0;
        1:       data_ready = 1'b1;
        default: data_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"},    flash_cs, 1);
    check({tag, "_sclk"},  flash_clk, 0);
    check({tag, "_mosi"},  flash_mosi, 0);
    check({tag, "_valid"}, data_valid, 0);
    check({tag, "_data"},  data_out, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_busy"},  busy, 1);
    check({tag, "_state"}, 32'(state), 32'(POWER_WAIT));
  endtask

  // Called with rst high, at #1 after a clock edge.
  task automatic power_up();
    int n = 0;
    int cs_low = 0;
    rst = 1'b0;
    forever begin
      @(negedge clk);
      if (!busy || n >= 1000) break;
      n++;
      if (!flash_cs) cs_low++;
    end
    check("power_wait_busy_cycles", n, STARTUP_WAIT + 1);
    check("power_wait_cs_low_cycles", cs_low, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic pulse_start(input logic [23:0] a, input logic [19:0] c);
    start = 1'b1;
    start_address = a;
    word_count = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_address = 24'($urandom);
    word_count = 20'($urandom);
  endtask

  task automatic push_expected(input logic [23:0] a, input int c);
    for (int k = 0; k < c; k++) exp_q.push_back(ref_word(a, k));
    if (c != 0) cmd_q.push_back({FLASH_CMD_READ, a});
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", done_cnt != d0, 1);
  endtask

  task automatic finish_checks(input int d0, input int f0, input int c);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_cnt - d0, 1);
    check("words_drained", exp_q.size(), 0);
    check("command_sent", cmd_q.size(), 0);
    check("cs_released", flash_cs, 1);
    check("idle_after_done", busy, 0);
    check("cs_select_count", cs_falls - f0, (c != 0) ? 1 : 0);
  endtask

  task automatic run_transfer(input logic [23:0] a, input int c, input bit inject);
    int d0;
    int f0;
    wait_idle();
    d0 = done_cnt;
    f0 = cs_falls;
    push_expected(a, c);
    pulse_start(a, 20'(c));
    start_cycle = cyc;
    if (inject) begin
      repeat (40) @(posedge clk);
      #1;
      check("busy_at_second_start", busy, 1);
      pulse_start(24'($urandom), 20'($urandom_range(1, 7)));
    end
    wait_done(d0);
    if (c == 0) check("zero_count_done_latency", (last_done_cycle - start_cycle) <= 2, 1);
    finish_checks(d0, f0, c);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [23:0] a;
    int d0;
    int f0;
    int w0;
    int r0;
    int n;

    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[4] = 8'h20;
    mem[5] = 8'h41;
    rst = 1'b1;
    start = 1'b0;
    start_address = '0;
    word_count = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    power_up();

    // Single word from address 4.
    ready_mode = 1;
    run_transfer(24'd4, 1, 1'b0);
    check("addr4_low_half", last_word[15:0], 16'h4120);

    // Zero-length transfer.
    run_transfer(24'($urandom), 0, 1'b0);

    // Back-pressure: hold ready low long enough to force STALL.
    wait_idle();
    ready_mode = 0;
    a = 24'($urandom);
    d0 = done_cnt;
    f0 = cs_falls;
    push_expected(a, 3);
    pulse_start(a, 20'd3);
    n = 0;
    while (!data_valid && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    check("first_word_valid", data_valid, 1);
    repeat (100) @(posedge clk);
    #1;
    r0 = clk_rises;
    repeat (100) @(posedge clk);
    #1;
    check("stall_clk_frozen", clk_rises - r0, 0);
    check("stall_clk_low", flash_clk, 0);
    check("stall_cs_low", flash_cs, 0);
    check("stall_state", 32'(state), 32'(STALL));
    check("stall_valid_held", data_valid, 1);
    check("stall_word_held", data_out, ref_word(a, 0));
    ready_mode = 1;
    wait_done(d0);
    finish_checks(d0, f0, 3);

    // Start while busy must be ignored.
    run_transfer(24'($urandom), 2, 1'b1);

    // Reset during the second word.
    wait_idle();
    a = 24'($urandom);
    push_expected(a, 3);
    w0 = words_seen;
    pulse_start(a, 20'd3);
    n = 0;
    while (words_seen == w0 && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    check("word1_before_reset", words_seen - w0, 1);
    repeat (20) @(posedge clk);
    #1;
    check("reading_word2", 32'(state), 32'(READ));
    ready_mode = 0;
    rst = 1'b1;
    exp_q.delete();
    cmd_q.delete();
    @(posedge clk);
    #1;
    check_reset_outputs("abort");
    power_up();
    ready_mode = 1;
    run_transfer(24'($urandom), 2, 1'b0);

    // Randomized transfers with random back-pressure, including address wrap.
    ready_mode = 2;
    for (int t = 0; t < 10; t++) begin
      if (t == 3) a = 24'hFFFFFF - 24'($urandom_range(0, 6));
      else        a = 24'($urandom);
      run_transfer(a, (t == 6) ? 0 : $urandom_range(1, 4), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
